// File: rtl/async_mux_pipe.sv
// Two-stage COUNT:1 word selector: stage 1 picks one word per RADIX-sized group, stage 2 picks the group.
// Latency 2 cycles accept-to-m_valid; s_ready falls only when both stages hold data and m_ready is low.
module async_mux_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int COUNT      = 16,
    parameter int ADDR_WIDTH = $clog2(COUNT),
    parameter int RADIX      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [COUNT*DATA_WIDTH-1:0] s_data,
    input  logic [ADDR_WIDTH-1:0]       s_select,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic [ADDR_WIDTH-1:0]       m_select,
    output logic                        m_err,
    output logic                        m_valid,
    input  logic                        m_ready
);

    localparam int GROUPS = (COUNT + RADIX - 1) / RADIX;
    localparam int LOG_R  = $clog2(RADIX);
    localparam int HI_W   = (ADDR_WIDTH > LOG_R) ? ADDR_WIDTH - LOG_R : 1;
    localparam logic [ADDR_WIDTH:0] COUNT_W = (ADDR_WIDTH + 1)'(COUNT);

    // Last group is zero-padded so its unused slots read 0 instead of aliasing.
    logic [DATA_WIDTH-1:0] word_pad [GROUPS][RADIX];

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        for (genvar r = 0; r < RADIX; r++) begin : g_slot
            if (g * RADIX + r < COUNT) begin : g_real
                assign word_pad[g][r] = s_data[(g*RADIX + r)*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_pad
                assign word_pad[g][r] = '0;
            end
        end
    end

    logic [DATA_WIDTH-1:0] grp_q [GROUPS];
    logic [ADDR_WIDTH-1:0] st1_sel;
    logic                  st1_err;
    logic                  st1_valid;
    logic [LOG_R-1:0]      s_lo;
    logic [HI_W-1:0]       st1_hi;
    logic [DATA_WIDTH-1:0] sel_word;
    logic                  out_adv;
    logic                  s_acc;

    assign out_adv = st1_valid && (!m_valid || m_ready);
    assign s_ready = !st1_valid || out_adv;
    assign s_acc   = s_valid && s_ready;
    assign s_lo    = s_select[LOG_R-1:0];
    assign st1_hi  = HI_W'(st1_sel >> LOG_R);

    always_comb begin
        sel_word = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (st1_hi == HI_W'(g)) sel_word = grp_q[g];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < GROUPS; g++) grp_q[g] <= '0;
            st1_sel   <= '0;
            st1_err   <= 1'b0;
            st1_valid <= 1'b0;
        end else begin
            if (s_acc) begin
                for (int g = 0; g < GROUPS; g++) grp_q[g] <= word_pad[g][s_lo];
                st1_sel <= s_select;
                st1_err <= ({1'b0, s_select} >= COUNT_W);
            end
            if (s_acc)        st1_valid <= 1'b1;
            else if (out_adv) st1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data   <= '0;
            m_select <= '0;
            m_err    <= 1'b0;
            m_valid  <= 1'b0;
        end else begin
            if (out_adv) begin
                m_data   <= st1_err ? '0 : sel_word;
                m_select <= st1_sel;
                m_err    <= st1_err;
            end
            if (out_adv)      m_valid <= 1'b1;
            else if (m_ready) m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_async_mux_pipe.sv
// Bench for async_mux_pipe: a 16-word instance against a queue-based request model, plus a 12-word instance for range errors.
module tb_async_mux_pipe;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] s_data;
    logic [3:0]   s_select;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   m_data;
    logic [3:0]   m_select;
    logic         m_err;
    logic         m_valid;
    logic         m_ready;

    logic [95:0]  s2_data;
    logic [3:0]   s2_select;
    logic         s2_valid;
    logic         s2_ready;
    logic [7:0]   m2_data;
    logic [3:0]   m2_select;
    logic         m2_err;
    logic         m2_valid;
    logic         m2_ready;

    always #5 clk = ~clk;

    async_mux_pipe #(.DATA_WIDTH(8), .COUNT(16), .RADIX(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_select(s_select),
        .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_select(m_select),
        .m_err(m_err), .m_valid(m_valid), .m_ready(m_ready)
    );

    async_mux_pipe #(.DATA_WIDTH(8), .COUNT(12), .RADIX(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .s_data(s2_data), .s_select(s2_select),
        .s_valid(s2_valid), .s_ready(s2_ready), .m_data(m2_data), .m_select(m2_select),
        .m_err(m2_err), .m_valid(m2_valid), .m_ready(m2_ready)
    );

    typedef struct {
        int         acc;
        logic [7:0] d;
        logic [3:0] s;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic       obs_s_ready, obs_m_valid, obs_m_err;
    logic [7:0] obs_m_data;
    logic [3:0] obs_m_select;
    logic       exp_s_ready, exp_m_valid;
    ent_t       exp_head;
    logic       fire_in, fire_out;

    function automatic logic [127:0] pattern_a0();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'hA0 + 8'(i);
        return v;
    endfunction

    // Request model: an accepted request is visible two cycles later, oldest first;
    // at most two may be in flight, so input is refused only when two wait and m_ready is low.
    task automatic drive_cycle(input logic v, input logic [3:0] sel,
                               input logic [127:0] dat, input logic mr);
        ent_t e;
        @(negedge clk);
        s_valid = v; s_select = sel; s_data = dat; m_ready = mr;
        #1;
        obs_s_ready  = s_ready;
        obs_m_valid  = m_valid;
        obs_m_data   = m_data;
        obs_m_select = m_select;
        obs_m_err    = m_err;
        exp_s_ready  = !(q.size() == 2 && !mr);
        exp_m_valid  = (q.size() > 0) && (cyc >= q[0].acc + 2);
        if (exp_m_valid) exp_head = q[0];
        fire_in  = v && exp_s_ready;
        fire_out = exp_m_valid && mr;
        @(posedge clk);
        if (fire_out) void'(q.pop_front());
        if (fire_in) begin
            e.acc = cyc;
            e.d   = dat[int'(sel)*8 +: 8];
            e.s   = sel;
            q.push_back(e);
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_valid = 0; s_select = 0; s_data = '0; m_ready = 0;
        s2_valid = 0; s2_select = 0; s2_data = '0; m2_ready = 1;
        #12;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
        tests++; if (m_select !== 4'h0) begin fails++; $display("FAIL reset_m_select got=%h exp=0", m_select); end
        tests++; if (m_err !== 1'b0) begin fails++; $display("FAIL reset_m_err got=%b exp=0", m_err); end
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        tests++; if (m2_valid !== 1'b0) begin fails++; $display("FAIL reset_m2_valid got=%b exp=0", m2_valid); end
        @(negedge clk); rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_stream();
        logic [127:0] pat = pattern_a0();
        int n_out = 0;
        for (int i = 0; i < 19; i++) begin
            drive_cycle(i < 16, 4'(i), pat, 1'b1);
            tests++;
            if (obs_m_valid !== exp_m_valid) begin
                fails++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, obs_m_valid, exp_m_valid);
            end
            if (exp_m_valid) begin
                tests++;
                if (obs_m_data !== 8'hA0 + 8'(n_out) || obs_m_err !== 1'b0) begin
                    fails++; $display("FAIL stream_data n=%0d got=%h/%b exp=%h/0", n_out, obs_m_data, obs_m_err, 8'hA0 + 8'(n_out));
                end
                n_out++;
            end
        end
        tests++; if (n_out !== 16) begin fails++; $display("FAIL stream_count got=%0d exp=16", n_out); end
    endtask

    task automatic test_stall();
        logic [127:0] pat = pattern_a0();
        logic [7:0] seen [$];
        drive_cycle(1'b1, 4'd5, pat, 1'b0);
        drive_cycle(1'b1, 4'd9, pat, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 4'd0, pat, 1'b0);
            tests++;
            if (obs_s_ready !== 1'b0 || obs_m_valid !== 1'b1 || obs_m_data !== 8'hA5) begin
                fails++; $display("FAIL stall_hold i=%0d rdy=%b vld=%b data=%h exp rdy=0 vld=1 data=a5", i, obs_s_ready, obs_m_valid, obs_m_data);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 4'd0, pat, 1'b1);
            if (obs_m_valid) seen.push_back(obs_m_data);
        end
        tests++;
        if (seen.size() != 2 || seen[0] !== 8'hA5 || seen[1] !== 8'hA9) begin
            fails++; $display("FAIL stall_release got n=%0d exp a5,a9", seen.size());
        end
    endtask

    task automatic test_sample_hold();
        logic [127:0] d1 = {4{$urandom()}};
        logic [7:0] want = d1[3*8 +: 8];
        int hits = 0;
        drive_cycle(1'b1, 4'd3, d1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 4'd3, ~d1, 1'b1);
            if (obs_m_valid) begin
                hits++;
                tests++;
                if (obs_m_data !== want) begin fails++; $display("FAIL sample_hold got=%h exp=%h", obs_m_data, want); end
            end
        end
        tests++; if (hits !== 1) begin fails++; $display("FAIL sample_hold_count got=%0d exp=1", hits); end
    endtask

    task automatic test_reset_midflight();
        logic [127:0] pat = pattern_a0();
        int hits = 0;
        drive_cycle(1'b1, 4'd1, pat, 1'b0);
        drive_cycle(1'b1, 4'd2, pat, 1'b0);
        @(negedge clk); s_valid = 0;
        rst_n = 1'b0;
        #1;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL midreset_m_valid got=%b exp=0", m_valid); end
        @(negedge clk); rst_n = 1'b1;
        q.delete();
        #1;
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL midreset_s_ready got=%b exp=1", s_ready); end
        drive_cycle(1'b1, 4'd7, pat, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 4'd0, pat, 1'b1);
            tests++;
            if (obs_m_valid !== (i == 1)) begin fails++; $display("FAIL midreset_timing i=%0d got=%b exp=%b", i, obs_m_valid, i == 1); end
            if (obs_m_valid) begin
                hits++;
                tests++;
                if (obs_m_data !== 8'hA7 || obs_m_select !== 4'd7) begin
                    fails++; $display("FAIL midreset_data got=%h/%h exp=a7/7", obs_m_data, obs_m_select);
                end
            end
        end
        tests++; if (hits !== 1) begin fails++; $display("FAIL midreset_count got=%0d exp=1", hits); end
    endtask

    task automatic test_count12();
        logic [3:0] sels [6] = '{4'd0, 4'd5, 4'd11, 4'd12, 4'd13, 4'd15};
        logic [7:0] want;
        logic       werr;
        for (int i = 0; i < 12; i++) s2_data[i*8 +: 8] = 8'hB0 + 8'(i);
        m2_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); s2_valid = 1'b1; s2_select = sels[k];
            @(negedge clk); s2_valid = 1'b0;
            @(negedge clk); #1;
            werr = (sels[k] >= 4'd12);
            want = werr ? 8'h00 : 8'hB0 + 8'(sels[k]);
            tests++;
            if (m2_valid !== 1'b1 || m2_data !== want || m2_err !== werr || m2_select !== sels[k]) begin
                fails++; $display("FAIL count12 sel=%0d got vld=%b data=%h err=%b sel=%0d exp data=%h err=%b",
                                  sels[k], m2_valid, m2_data, m2_err, m2_select, want, werr);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int n_in = 0, n_out = 0, guard = 0;
        logic v, mr;
        while ((n_in < 10000 || q.size() > 0) && guard < 60000) begin
            v  = (n_in < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            mr = (n_in < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
            drive_cycle(v, 4'($urandom()), {4{$urandom()}}, mr);
            guard++;
            if (fire_in) n_in++;
            if (obs_m_valid && mr) n_out++;
            tests++;
            if (obs_s_ready !== exp_s_ready || obs_m_valid !== exp_m_valid) begin
                fails++; $display("FAIL random_hs cyc=%0d rdy=%b/%b vld=%b/%b", guard, obs_s_ready, exp_s_ready, obs_m_valid, exp_m_valid);
            end
            if (exp_m_valid) begin
                tests++;
                if (obs_m_data !== exp_head.d || obs_m_select !== exp_head.s || obs_m_err !== 1'b0) begin
                    fails++; $display("FAIL random_data cyc=%0d got=%h/%h/%b exp=%h/%h/0", guard, obs_m_data, obs_m_select, obs_m_err, exp_head.d, exp_head.s);
                end
            end
        end
        tests++; if (guard >= 60000) begin fails++; $display("FAIL random_timeout cycles=%0d limit=60000", guard); end
        tests++; if (n_out !== n_in) begin fails++; $display("FAIL random_count got=%0d exp=%0d", n_out, n_in); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_sample_hold();
        test_reset_midflight();
        test_count12();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
